// File: rtl/stream_sel_mux.sv
// stream_sel_mux: registered N-channel packet multiplexer with valid/ready
// handshakes. A channel is granted per packet, either by the external select
// or by round-robin, and keeps the grant until its last beat is accepted.
module stream_sel_mux #(
   parameter int  WIDTH    = 2,
   parameter int  CHANNELS = 2,
   parameter int  ARB_MODE = 0,
   localparam int SELW     = $clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rstN,
   input  logic [CHANNELS*WIDTH-1:0] inData,
   input  logic [CHANNELS-1:0]       inValid,
   input  logic [CHANNELS-1:0]       inLast,
   output logic [CHANNELS-1:0]       inReady,
   input  logic [SELW-1:0]           sel,
   output logic [WIDTH-1:0]          outData,
   output logic                      outValid,
   output logic                      outLast,
   output logic [SELW-1:0]           outChan,
   input  logic                      outReady
);

   localparam int unsigned NCH = CHANNELS;

   typedef enum logic {
      ST_IDLE,
      ST_BUSY
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [SELW-1:0]   r_grant;
   logic [SELW-1:0]   r_ptr;
   logic [SELW-1:0]   w_cand;
   logic              w_cand_ok;
   logic [SELW-1:0]   w_idx;
   logic [WIDTH-1:0]  w_beat;
   logic              w_beat_last;
   logic              w_gnt_valid;
   logic              w_xfer;
   logic [WIDTH-1:0]  r_outData;
   logic              r_outValid;
   logic              r_outLast;
   logic [SELW-1:0]   r_outChan;

   // Candidate channel for the next grant: external select or round-robin search
   always_comb begin
      w_cand    = '0;
      w_cand_ok = 1'b0;
      w_idx     = '0;
      if (ARB_MODE == 0) begin
         if (32'(sel) < NCH) begin
            w_cand    = sel;
            w_cand_ok = inValid[sel];
         end
      end else begin
         // search starts one past the last granted channel and wraps
         for (int unsigned off = 1; off <= NCH; off++) begin
            w_idx = SELW'((32'(r_ptr) + off) % NCH);
            if (!w_cand_ok && inValid[w_idx]) begin
               w_cand    = w_idx;
               w_cand_ok = 1'b1;
            end
         end
      end
   end

   // Route the granted channel's beat, last flag and valid
   always_comb begin
      w_beat      = '0;
      w_beat_last = 1'b0;
      w_gnt_valid = 1'b0;
      for (int unsigned c = 0; c < NCH; c++) begin
         if (r_grant == SELW'(c)) begin
            w_beat      = inData[c*WIDTH +: WIDTH];
            w_beat_last = inLast[c];
            w_gnt_valid = inValid[c];
         end
      end
   end

   // State register
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state: grant in IDLE, release after the last beat transfers
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_cand_ok) w_state_nxt = ST_BUSY;
         ST_BUSY: if (w_xfer && w_beat_last) w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // FSM outputs: per-channel ready and the beat-transfer strobe
   always_comb begin
      inReady = '0;
      w_xfer  = 1'b0;
      if (r_state == ST_BUSY) begin
         for (int unsigned c = 0; c < NCH; c++) begin
            if (r_grant == SELW'(c)) begin
               inReady[c] = !r_outValid || outReady;
            end
         end
         w_xfer = w_gnt_valid && (!r_outValid || outReady);
      end
   end

   // Grant and round-robin pointer, captured on the IDLE decision cycle
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_grant <= '0;
         r_ptr   <= SELW'(NCH - 1);
      end else if (r_state == ST_IDLE && w_cand_ok) begin
         r_grant <= w_cand;
         if (ARB_MODE != 0) begin
            r_ptr <= w_cand;
         end
      end
   end

   // Output register: load on transfer, drain on outReady, otherwise hold
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_outData  <= '0;
         r_outValid <= 1'b0;
         r_outLast  <= 1'b0;
         r_outChan  <= '0;
      end else if (w_xfer) begin
         r_outData  <= w_beat;
         r_outValid <= 1'b1;
         r_outLast  <= w_beat_last;
         r_outChan  <= r_grant;
      end else if (outReady) begin
         r_outValid <= 1'b0;
      end
   end

   assign outData  = r_outData;
   assign outValid = r_outValid;
   assign outLast  = r_outLast;
   assign outChan  = r_outChan;

endmodule

// File: tb/tb_stream_sel_mux.sv
// Bench for stream_sel_mux: a 3-channel select-mode instance and a
// 4-channel round-robin instance, each with an output scoreboard.
module tb_stream_sel_mux;

   logic clk;
   logic rstN;

   // instance A: WIDTH=2, CHANNELS=3, external select
   logic [5:0] a_inData;
   logic [2:0] a_inValid, a_inLast, a_inReady;
   logic [1:0] a_sel, a_outData, a_outChan;
   logic       a_outValid, a_outLast, a_outReady;

   // instance B: WIDTH=2, CHANNELS=4, round-robin
   logic [7:0] b_inData;
   logic [3:0] b_inValid, b_inLast, b_inReady;
   logic [1:0] b_sel, b_outData, b_outChan;
   logic       b_outValid, b_outLast, b_outReady;

   int errors = 0;
   int checks = 0;
   int w;

   logic [4:0] qa[$];
   logic [4:0] qb[$];
   logic [4:0] a_exp, b_exp;

   stream_sel_mux #(.WIDTH(2), .CHANNELS(3), .ARB_MODE(0)) u_a (
      .clk(clk), .rstN(rstN), .inData(a_inData), .inValid(a_inValid),
      .inLast(a_inLast), .inReady(a_inReady), .sel(a_sel),
      .outData(a_outData), .outValid(a_outValid), .outLast(a_outLast),
      .outChan(a_outChan), .outReady(a_outReady)
   );

   stream_sel_mux #(.WIDTH(2), .CHANNELS(4), .ARB_MODE(1)) u_b (
      .clk(clk), .rstN(rstN), .inData(b_inData), .inValid(b_inValid),
      .inLast(b_inLast), .inReady(b_inReady), .sel(b_sel),
      .outData(b_outData), .outValid(b_outValid), .outLast(b_outLast),
      .outChan(b_outChan), .outReady(b_outReady)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // scoreboard A: every accepted output beat must match the next expected entry
   always @(negedge clk) begin
      if (rstN && a_outValid && a_outReady) begin
         checks++;
         if (qa.size() == 0) begin
            errors++;
            $display("FAIL a_extra_beat got chan=%0d last=%0b data=%0h, expected no beat",
                     a_outChan, a_outLast, a_outData);
         end else begin
            a_exp = qa.pop_front();
            if ({a_outChan, a_outLast, a_outData} !== a_exp) begin
               errors++;
               $display("FAIL a_beat got chan=%0d last=%0b data=%0h, expected chan=%0d last=%0b data=%0h",
                        a_outChan, a_outLast, a_outData, a_exp[4:3], a_exp[2], a_exp[1:0]);
            end
         end
      end
   end

   // scoreboard B
   always @(negedge clk) begin
      if (rstN && b_outValid && b_outReady) begin
         checks++;
         if (qb.size() == 0) begin
            errors++;
            $display("FAIL b_extra_beat got chan=%0d last=%0b data=%0h, expected no beat",
                     b_outChan, b_outLast, b_outData);
         end else begin
            b_exp = qb.pop_front();
            if ({b_outChan, b_outLast, b_outData} !== b_exp) begin
               errors++;
               $display("FAIL b_beat got chan=%0d last=%0b data=%0h, expected chan=%0d last=%0b data=%0h",
                        b_outChan, b_outLast, b_outData, b_exp[4:3], b_exp[2], b_exp[1:0]);
            end
         end
      end
   end

   // present one beat on instance A, record it, wait (bounded) until accepted
   task automatic drive_a(input int ch, input logic [1:0] d, input logic l, output int waits);
      logic acc;
      a_inValid[ch]        = 1'b1;
      a_inData[ch*2 +: 2]  = d;
      a_inLast[ch]         = l;
      qa.push_back({2'(ch), l, d});
      acc   = 1'b0;
      waits = 0;
      while (!acc && waits < 20) begin
         @(negedge clk);
         acc = a_inReady[ch];
         @(posedge clk);
         #1;
         waits++;
      end
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL a_accept_timeout ch=%0d got no inReady, expected accept within 20 cycles", ch);
      end
   endtask

   task automatic drive_b(input int ch, input logic [1:0] d, input logic l, output int waits);
      logic acc;
      b_inValid[ch]        = 1'b1;
      b_inData[ch*2 +: 2]  = d;
      b_inLast[ch]         = l;
      qb.push_back({2'(ch), l, d});
      acc   = 1'b0;
      waits = 0;
      while (!acc && waits < 20) begin
         @(negedge clk);
         acc = b_inReady[ch];
         @(posedge clk);
         #1;
         waits++;
      end
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL b_accept_timeout ch=%0d got no inReady, expected accept within 20 cycles", ch);
      end
   endtask

   task automatic test_reset();
      rstN = 1'b0;
      a_inData = '0; a_inValid = '0; a_inLast = '0; a_sel = '0; a_outReady = 1'b1;
      b_inData = '0; b_inValid = '0; b_inLast = '0; b_sel = '0; b_outReady = 1'b1;
      #3;
      checks++;
      if ({a_outValid, a_outLast, a_outData, a_outChan, a_inReady} !== 9'b0) begin
         errors++;
         $display("FAIL a_reset_outputs got %b, expected 0", {a_outValid, a_outLast, a_outData, a_outChan, a_inReady});
      end
      checks++;
      if ({b_outValid, b_outLast, b_outData, b_outChan, b_inReady} !== 10'b0) begin
         errors++;
         $display("FAIL b_reset_outputs got %b, expected 0", {b_outValid, b_outLast, b_outData, b_outChan, b_inReady});
      end
      #18 rstN = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_mode0_packet();
      a_outReady = 1'b1;
      a_sel      = 2'd1;
      drive_a(1, 2'b01, 1'b0, w);
      checks++;
      if (w !== 2) begin errors++; $display("FAIL a_first_beat_wait got %0d, expected 2", w); end
      drive_a(1, 2'b10, 1'b0, w);
      checks++;
      if (w !== 1) begin errors++; $display("FAIL a_second_beat_wait got %0d, expected 1", w); end
      drive_a(1, 2'b11, 1'b1, w);
      checks++;
      if (w !== 1) begin errors++; $display("FAIL a_third_beat_wait got %0d, expected 1", w); end
      a_inValid[1] = 1'b0;
      a_inLast[1]  = 1'b0;
      @(negedge clk);
      checks++;
      if (a_inReady !== 3'b000) begin errors++; $display("FAIL a_idle_bubble_ready got %b, expected 000", a_inReady); end
      checks++;
      if (a_outValid !== 1'b1) begin errors++; $display("FAIL a_last_visible got %b, expected 1", a_outValid); end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (a_outValid !== 1'b0) begin errors++; $display("FAIL a_drain got outValid=%b, expected 0", a_outValid); end
      @(posedge clk); #1;
      checks++;
      if (qa.size() !== 0) begin errors++; $display("FAIL a_mode0_pending got %0d beats, expected 0", qa.size()); end
   endtask

   task automatic test_sel_switch();
      a_inValid[0]  = 1'b1;
      a_inData[1:0] = 2'b10;
      a_inLast[0]   = 1'b1;
      a_sel         = 2'd1;
      drive_a(1, 2'b11, 1'b0, w);
      checks++;
      if (w !== 2) begin errors++; $display("FAIL a_switch_first_wait got %0d, expected 2", w); end
      a_sel = 2'd0;
      drive_a(1, 2'b00, 1'b0, w);
      drive_a(1, 2'b01, 1'b1, w);
      a_inValid[1] = 1'b0;
      a_inLast[1]  = 1'b0;
      drive_a(0, 2'b10, 1'b1, w);
      checks++;
      if (w !== 2) begin errors++; $display("FAIL a_switch_next_grant_wait got %0d, expected 2", w); end
      a_inValid[0] = 1'b0;
      a_inLast[0]  = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      checks++;
      if (qa.size() !== 0) begin errors++; $display("FAIL a_switch_pending got %0d beats, expected 0", qa.size()); end
   endtask

   task automatic test_backpressure();
      a_sel      = 2'd1;
      a_outReady = 1'b1;
      drive_a(1, 2'b01, 1'b0, w);
      a_outReady    = 1'b0;
      a_inData[3:2] = 2'b10;
      a_inLast[1]   = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (a_outValid !== 1'b1) begin errors++; $display("FAIL a_stall_valid cyc=%0d got %b, expected 1", i, a_outValid); end
         checks++;
         if (a_outData !== 2'b01) begin errors++; $display("FAIL a_stall_data cyc=%0d got %b, expected 01", i, a_outData); end
         checks++;
         if (a_inReady[1] !== 1'b0) begin errors++; $display("FAIL a_stall_ready cyc=%0d got %b, expected 0", i, a_inReady[1]); end
         @(posedge clk); #1;
      end
      a_outReady = 1'b1;
      drive_a(1, 2'b10, 1'b0, w);
      checks++;
      if (w !== 1) begin errors++; $display("FAIL a_release_accept_wait got %0d, expected 1", w); end
      drive_a(1, 2'b11, 1'b1, w);
      a_inValid[1] = 1'b0;
      a_inLast[1]  = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      checks++;
      if (qa.size() !== 0) begin errors++; $display("FAIL a_bp_pending got %0d beats, expected 0", qa.size()); end
   endtask

   task automatic test_out_of_range();
      a_sel     = 2'd3;
      a_inValid = 3'b111;
      a_inLast  = 3'b111;
      a_inData  = 6'b11_10_01;
      repeat (5) begin
         @(negedge clk);
         checks++;
         if (a_outValid !== 1'b0) begin errors++; $display("FAIL a_oor_valid got %b, expected 0", a_outValid); end
         checks++;
         if (a_inReady !== 3'b000) begin errors++; $display("FAIL a_oor_ready got %b, expected 000", a_inReady); end
         @(posedge clk); #1;
      end
      a_inValid = '0;
      a_inLast  = '0;
      a_sel     = '0;
   endtask

   task automatic test_round_robin();
      b_outReady = 1'b1;
      b_inLast   = 4'hF;
      b_inData   = 8'b11_10_01_00;
      b_inValid  = 4'hF;
      for (int i = 0; i < 5; i++) begin
         drive_b(i % 4, 2'(i % 4), 1'b1, w);
         checks++;
         if (w !== 2) begin errors++; $display("FAIL b_rr_wait pkt=%0d got %0d, expected 2", i, w); end
      end
      b_inValid = '0;
      repeat (2) begin @(posedge clk); #1; end
      checks++;
      if (qb.size() !== 0) begin errors++; $display("FAIL b_rr_pending got %0d beats, expected 0", qb.size()); end
   endtask

   task automatic test_reset_midpacket();
      b_inValid = 4'b0000;
      b_inLast  = 4'b0000;
      drive_b(2, 2'b11, 1'b0, w);
      checks++;
      if (w !== 2) begin errors++; $display("FAIL b_mid_first_wait got %0d, expected 2", w); end
      @(negedge clk);
      #1 rstN = 1'b0;
      #1;
      checks++;
      if (b_outValid !== 1'b0) begin errors++; $display("FAIL b_async_valid got %b, expected 0", b_outValid); end
      checks++;
      if (b_inReady !== 4'b0000) begin errors++; $display("FAIL b_async_ready got %b, expected 0000", b_inReady); end
      checks++;
      if ({b_outData, b_outChan, b_outLast} !== 5'b0) begin
         errors++;
         $display("FAIL b_async_regs got %b, expected 00000", {b_outData, b_outChan, b_outLast});
      end
      b_inValid = '0;
      #1 rstN = 1'b1;
      @(posedge clk); #1;
      b_inData  = 8'b11_10_01_00;
      b_inLast  = 4'hF;
      b_inValid = 4'hF;
      drive_b(0, 2'b00, 1'b1, w);
      checks++;
      if (w !== 2) begin errors++; $display("FAIL b_post_reset_wait got %0d, expected 2", w); end
      b_inValid = '0;
      repeat (2) begin @(posedge clk); #1; end
      checks++;
      if (qb.size() !== 0) begin errors++; $display("FAIL b_post_reset_pending got %0d beats, expected 0", qb.size()); end
   endtask

   initial begin
      test_reset();
      test_mode0_packet();
      test_sel_switch();
      test_backpressure();
      test_out_of_range();
      test_round_robin();
      test_reset_midpacket();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got no completion, expected finish before 200000");
      $fatal(1, "timeout");
   end

endmodule
